ds_fetch_decode: RTL and testbench

DS_FETCH_DECODE -- requirements
Module: ds_fetch_decode

---
 rtl/ds_pkg.sv | 49 ++++
 rtl/ds_field_split.sv | 53 +++++
 rtl/ds_fetch_decode.sv | 144 ++++++++++++++
 tb/tb_ds_fetch_decode.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ds_pkg.sv
// Shared constants and types for the DS-format fetch/decode slice (ld / std words).
// Optional XO legality checking is enabled by the DS_XO_CHECK_EN macro.
package ds_pkg;

  localparam logic [5:0] PO_LD  = 6'd58;
  localparam logic [5:0] PO_STD = 6'd62;

  // Field bit positions inside the 32-bit instruction word
  localparam int PO_MSB = 31;
  localparam int PO_LSB = 26;
  localparam int RT_MSB = 25;
  localparam int RT_LSB = 21;
  localparam int RA_MSB = 20;
  localparam int RA_LSB = 16;
  localparam int DS_MSB = 15;
  localparam int DS_LSB = 2;
  localparam int XO_MSB = 1;
  localparam int XO_LSB = 0;

  // Largest XO value that is legal for each primary opcode
  localparam logic [1:0] XO_LD_MAX  = 2'd2;
  localparam logic [1:0] XO_STD_MAX = 2'd1;

  localparam logic [15:0] ILLEGAL_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [5:0]  po;
    logic [4:0]  rt;
    logic [4:0]  ra;
    logic [14:0] ds;
    logic [1:0]  xo;
    logic        is_load;
    logic        is_store;
    logic        illegal;
    logic [63:0] ea_off;
  } dec_t;

  // Byte displacement: word displacement scaled by 4, sign-extended to 64 bits
  function automatic logic [63:0] sext_disp(input logic [13:0] ds14);
    return {{48{ds14[13]}}, ds14, 2'b00};
  endfunction

endpackage

// File: rtl/ds_field_split.sv
// Combinational decode of one raw word into DS-format fields, class and ea_off.
// With DS_XO_CHECK_EN defined, reserved XO encodings of ld/std are also flagged illegal.
module ds_field_split
  import ds_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [13:0] ds14_s;

  assign ds14_s = instr[DS_MSB:DS_LSB];

  // Field extraction and instruction classification
  always_comb begin
    dec          = '0;
    dec.po       = instr[PO_MSB:PO_LSB];
    dec.rt       = instr[RT_MSB:RT_LSB];
    dec.ra       = instr[RA_MSB:RA_LSB];
    dec.ds       = {ds14_s[13], ds14_s};
    dec.xo       = instr[XO_MSB:XO_LSB];
    dec.ea_off   = sext_disp(ds14_s);
    dec.is_load  = 1'b0;
    dec.is_store = 1'b0;
    dec.illegal  = 1'b0;
    case (dec.po)
      PO_LD: begin
`ifdef DS_XO_CHECK_EN
        if (dec.xo > XO_LD_MAX) begin
          dec.illegal = 1'b1;
        end else begin
          dec.is_load = 1'b1;
        end
`else
        dec.is_load = 1'b1;
`endif
      end
      PO_STD: begin
`ifdef DS_XO_CHECK_EN
        if (dec.xo > XO_STD_MAX) begin
          dec.illegal = 1'b1;
        end else begin
          dec.is_store = 1'b1;
        end
`else
        dec.is_store = 1'b1;
`endif
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ds_fetch_decode.sv
// Fetch/decode stage for DS-format words: decode at the input, two-entry skid buffer at the output.
// Define DS_XO_CHECK_EN to also reject reserved XO encodings (see ds_field_split).
module ds_fetch_decode
  import ds_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [5:0]  PO,
  output logic [4:0]  rt,
  output logic [4:0]  ra,
  output logic [14:0] DS,
  output logic [1:0]  XO,
  output logic        is_load,
  output logic        is_store,
  output logic        illegal,
  output logic [63:0] ea_off,
  output logic [15:0] illegal_cnt
);

  dec_t        in_dec_s;
  dec_t        out_r;
  dec_t        skid_r;
  state_t      state_r;
  state_t      state_nxt_s;
  logic        ready_r;
  logic        valid_r;
  logic [15:0] cnt_r;
  logic        accept_s;
  logic        drain_s;
  logic        load_out_in_s;
  logic        load_out_skid_s;
  logic        load_skid_s;

  ds_field_split u_split (
    .instr (instr),
    .dec   (in_dec_s)
  );

  // Ready and valid are registered copies of the state, so ready never sees dec_ready combinationally
  assign accept_s = instr_valid & ready_r;
  assign drain_s  = valid_r & dec_ready;

  // Next-state and buffer-load decisions
  always_comb begin
    state_nxt_s     = state_r;
    load_out_in_s   = 1'b0;
    load_out_skid_s = 1'b0;
    load_skid_s     = 1'b0;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept_s) begin
            state_nxt_s   = ST_ONE;
            load_out_in_s = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && drain_s) begin
            state_nxt_s   = ST_ONE;
            load_out_in_s = 1'b1;
          end else if (accept_s) begin
            state_nxt_s = ST_FULL;
            load_skid_s = 1'b1;
          end else if (drain_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (drain_s) begin
            state_nxt_s     = ST_ONE;
            load_out_skid_s = 1'b1;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: state_nxt_s = ST_EMPTY;
      endcase
    end
  end

  // State, handshake flags and buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
      ready_r <= 1'b0;
      valid_r <= 1'b0;
      out_r   <= '0;
      skid_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s != ST_FULL);
      valid_r <= (state_nxt_s != ST_EMPTY);
      if (load_out_in_s) begin
        out_r <= in_dec_s;
      end else if (load_out_skid_s) begin
        out_r <= skid_r;
      end else begin
        out_r <= out_r;
      end
      if (load_skid_s) begin
        skid_r <= in_dec_s;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

  // Illegal-word counter: counts accepted words only; a word taken during flush is discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 16'd0;
    end else if (!flush && accept_s && in_dec_s.illegal && (cnt_r != ILLEGAL_CNT_MAX)) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign instr_ready = ready_r;
  assign dec_valid   = valid_r;
  assign PO          = out_r.po;
  assign rt          = out_r.rt;
  assign ra          = out_r.ra;
  assign DS          = out_r.ds;
  assign XO          = out_r.xo;
  assign is_load     = out_r.is_load;
  assign is_store    = out_r.is_store;
  assign illegal     = out_r.illegal;
  assign ea_off      = out_r.ea_off;
  assign illegal_cnt = cnt_r;

endmodule

// File: tb/tb_ds_fetch_decode.sv
// Self-checking bench for ds_fetch_decode: directed scenarios plus randomized traffic vs a queue model.
module tb_ds_fetch_decode;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        dec_valid;
  logic        dec_ready;
  logic [5:0]  PO;
  logic [4:0]  rt;
  logic [4:0]  ra;
  logic [14:0] DS;
  logic [1:0]  XO;
  logic        is_load;
  logic        is_store;
  logic        illegal;
  logic [63:0] ea_off;
  logic [15:0] illegal_cnt;

  int checks;
  int failures;

  // Reference model state
  logic [31:0] mq[$];
  int          m_cnt;
  logic        m_rdy;

  ds_fetch_decode dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .PO          (PO),
    .rt          (rt),
    .ra          (ra),
    .DS          (DS),
    .XO          (XO),
    .is_load     (is_load),
    .is_store    (is_store),
    .illegal     (illegal),
    .ea_off      (ea_off),
    .illegal_cnt (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference legality from the opcode rules
  function automatic bit ref_illegal(input logic [31:0] w);
    int po;
    int xo;
    po = int'(w >> 26) & 63;
    xo = int'(w) & 3;
`ifdef DS_XO_CHECK_EN
    if (po == 58) return (xo == 3);
    if (po == 62) return (xo > 1);
`else
    if (po == 58 || po == 62) return 1'b0;
`endif
    return 1'b1;
  endfunction

  // Expected output bundle {PO,rt,ra,DS,XO,is_load,is_store,illegal,ea_off} computed arithmetically
  function automatic logic [101:0] ref_out(input logic [31:0] w);
    int po;
    int xo;
    int rtv;
    int rav;
    int ds14;
    longint disp;
    logic [5:0]  po_v;
    logic [4:0]  rt_v;
    logic [4:0]  ra_v;
    logic [14:0] ds_v;
    logic [1:0]  xo_v;
    logic [63:0] ea_v;
    bit ld;
    bit st;
    bit il;
    po   = int'(w >> 26) & 63;
    rtv  = int'(w >> 21) & 31;
    rav  = int'(w >> 16) & 31;
    ds14 = int'(w >> 2) & 16'h3FFF;
    xo   = int'(w) & 3;
    if (ds14 >= 8192) disp = longint'(ds14) - 64'sd16384;
    else disp = longint'(ds14);
    il   = ref_illegal(w);
    ld   = !il && (po == 58);
    st   = !il && (po == 62);
    po_v = po[5:0];
    rt_v = rtv[4:0];
    ra_v = rav[4:0];
    ds_v = disp[14:0];
    xo_v = xo[1:0];
    ea_v = disp * 64'sd4;
    return {po_v, rt_v, ra_v, ds_v, xo_v, ld, st, il, ea_v};
  endfunction

  // One clock: advance the model from the inputs seen at this edge, then settle past the edge
  task automatic cycle();
    bit acc;
    bit drn;
    @(posedge clk);
    acc = instr_valid && m_rdy;
    drn = (mq.size() > 0) && dec_ready;
    if (flush) begin
      mq.delete();
    end else begin
      if (drn) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(instr);
        if (ref_illegal(instr) && m_cnt < 65535) m_cnt++;
      end
    end
    m_rdy = (mq.size() < 2);
    #1;
  endtask

  task automatic idle_inputs();
    flush       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'h0;
    dec_ready   = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    mq.delete();
    m_cnt = 0;
    m_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({instr_ready, dec_valid, PO, rt, ra, DS, XO, is_load, is_store, illegal, ea_off, illegal_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b cnt=%h ea=%h", instr_ready, dec_valid, illegal_cnt, ea_off);
    end
    rst_n = 1'b1;
    cycle();
    checks++;
    if (instr_ready !== 1'b1 || dec_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got rdy=%b vld=%b, want rdy=1 vld=0", instr_ready, dec_valid);
    end
  endtask

  task automatic test_decode();
    logic [31:0] words[5];
    logic [101:0] exp_v;
    words[0] = 32'hE8430014;
    words[1] = 32'hF923001C;
    words[2] = 32'hE8EA0000;
    words[3] = 32'hE843FFFC;
    words[4] = 32'hF9230002;
    dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      instr_valid = 1'b1;
      instr = words[i];
      cycle();
      exp_v = ref_out(words[i]);
      checks++;
      if (dec_valid !== 1'b1 || {PO, rt, ra, DS, XO, is_load, is_store, illegal, ea_off} !== exp_v) begin
        failures++;
        $display("FAIL decode_%0d: got vld=%b out=%h, want out=%h", i, dec_valid,
                 {PO, rt, ra, DS, XO, is_load, is_store, illegal, ea_off}, exp_v);
      end
    end
    instr_valid = 1'b0;
    cycle();
    // Spot values worked out by hand
    checks++;
    if (ref_out(32'hE8430014) !== {6'd58, 5'd2, 5'd3, 15'd5, 2'd0, 1'b1, 1'b0, 1'b0, 64'd20}) begin
      failures++;
      $display("FAIL ref_ld_example: model disagrees with hand-decoded ld");
    end
    instr_valid = 1'b1;
    instr = 32'hE843FFFC;
    cycle();
    checks++;
    if (DS !== 15'h7FFF || ea_off !== 64'hFFFF_FFFF_FFFF_FFFC || is_load !== 1'b1) begin
      failures++;
      $display("FAIL neg_disp: got DS=%h ea=%h ld=%b, want DS=7fff ea=-4 ld=1", DS, ea_off, is_load);
    end
    instr = 32'hF9230002;
    cycle();
    checks++;
`ifdef DS_XO_CHECK_EN
    if (illegal !== 1'b1 || is_store !== 1'b0) begin
      failures++;
      $display("FAIL xo_check: got illegal=%b st=%b, want illegal=1", illegal, is_store);
    end
`else
    if (illegal !== 1'b0 || is_store !== 1'b1) begin
      failures++;
      $display("FAIL xo_passthru: got illegal=%b st=%b, want st=1", illegal, is_store);
    end
`endif
    instr = 32'h7C000000;
    cycle();
    checks++;
    if (illegal !== 1'b1 || is_load !== 1'b0 || is_store !== 1'b0 || illegal_cnt !== 16'(m_cnt) || m_cnt < 1) begin
      failures++;
      $display("FAIL illegal_word: got illegal=%b cnt=%0d, want illegal=1 cnt=%0d", illegal, illegal_cnt, m_cnt);
    end
    instr_valid = 1'b0;
    cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[3];
    w[0] = 32'hE8210008;
    w[1] = 32'hF8420010;
    w[2] = 32'hE8630018;
    dec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      instr_valid = 1'b1;
      instr = w[i];
      cycle();
    end
    checks++;
    if (instr_ready !== 1'b0 || dec_valid !== 1'b1 || rt !== 5'd1 || mq.size() != 2) begin
      failures++;
      $display("FAIL b2b_full: got rdy=%b vld=%b rt=%0d, want rdy=0 vld=1 rt=1", instr_ready, dec_valid, rt);
    end
    dec_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dec_valid !== 1'b1 || {PO, rt, ra, DS, XO, is_load, is_store, illegal, ea_off} !== ref_out(w[k])) begin
        failures++;
        $display("FAIL b2b_order_%0d: got vld=%b rt=%0d, want rt=%0d", k, dec_valid, rt, k + 1);
      end
      cycle();
      if (k == 1) instr_valid = 1'b0;
    end
    checks++;
    if (dec_valid !== 1'b0 || instr_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_drained: got vld=%b rdy=%b, want vld=0 rdy=1", dec_valid, instr_ready);
    end
  endtask

  task automatic test_flush();
    dec_ready = 1'b0;
    instr_valid = 1'b1;
    instr = 32'h7C000000;
    cycle();
    instr = 32'hE8430014;
    cycle();
    flush = 1'b1;
    instr = 32'h7C000000;
    cycle();
    flush = 1'b0;
    checks++;
    if (dec_valid !== 1'b0 || instr_ready !== 1'b1 || illegal_cnt !== 16'(m_cnt)) begin
      failures++;
      $display("FAIL flush_full: got vld=%b rdy=%b cnt=%0d, want vld=0 rdy=1 cnt=%0d", dec_valid, instr_ready, illegal_cnt, m_cnt);
    end
    instr = 32'hE8430014;
    cycle();
    flush = 1'b1;
    instr = 32'h7C000000;
    cycle();
    flush = 1'b0;
    instr_valid = 1'b0;
    checks++;
    if (dec_valid !== 1'b0 || illegal_cnt !== 16'(m_cnt)) begin
      failures++;
      $display("FAIL flush_accept: got vld=%b cnt=%0d, want vld=0 cnt=%0d", dec_valid, illegal_cnt, m_cnt);
    end
    cycle();
    checks++;
    if (dec_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_discard: got vld=%b, want 0", dec_valid);
    end
    dec_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    dec_ready = 1'b0;
    instr_valid = 1'b1;
    instr = 32'h7C000000;
    cycle();
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_cnt = 0;
    m_rdy = 1'b0;
    checks++;
    if (dec_valid !== 1'b0 || instr_ready !== 1'b0 || illegal_cnt !== 16'd0 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got vld=%b rdy=%b cnt=%0d illegal=%b, want all 0", dec_valid, instr_ready, illegal_cnt, illegal);
    end
    idle_inputs();
    #1;
    rst_n = 1'b1;
    cycle();
    checks++;
    if (instr_ready !== 1'b1 || dec_valid !== 1'b0) begin
      failures++;
      $display("FAIL async_release: got rdy=%b vld=%b, want rdy=1 vld=0", instr_ready, dec_valid);
    end
  endtask

  task automatic test_random();
    logic [101:0] exp_v;
    int sel;
    for (int n = 0; n < 500; n++) begin
      instr_valid = ($urandom_range(0, 3) != 0);
      dec_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 40) == 0);
      instr       = $urandom;
      sel         = $urandom_range(0, 3);
      if (sel == 0) instr[31:26] = 6'd58;
      else if (sel == 1) instr[31:26] = 6'd62;
      else if (sel == 2) instr[31:26] = 6'd58 ^ 6'd4;
      cycle();
      checks++;
      if (instr_ready !== m_rdy || dec_valid !== (mq.size() > 0) || illegal_cnt !== 16'(m_cnt)) begin
        failures++;
        $display("FAIL rand_ctrl_%0d: got rdy=%b vld=%b cnt=%0d, want rdy=%b vld=%b cnt=%0d",
                 n, instr_ready, dec_valid, illegal_cnt, m_rdy, (mq.size() > 0), m_cnt);
      end
      if (mq.size() > 0) begin
        exp_v = ref_out(mq[0]);
        checks++;
        if ({PO, rt, ra, DS, XO, is_load, is_store, illegal, ea_off} !== exp_v) begin
          failures++;
          $display("FAIL rand_data_%0d: got %h, want %h", n,
                   {PO, rt, ra, DS, XO, is_load, is_store, illegal, ea_off}, exp_v);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
